// File: rtl/useq_sequencer.sv
// rtl/useq_sequencer.sv - microprogram sequencer: uPC, control-store fetch, next-address select
// Drives the control unit's next-address mux and gates the control field during EXEC.
module useq_sequencer #(
  parameter int                ADDR_W     = 16,
  parameter int                JUMP_W     = 7,
  parameter int                CTRL_W     = 19,
  parameter logic [ADDR_W-1:0] START_ADDR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    map_addr,
  input  logic                 z_flag,
  input  logic                 core_done,
  output logic [ADDR_W-1:0]    cs_addr,
  output logic                 cs_rd,
  input  logic [13+CTRL_W-1:0] cs_data,
  output logic [1:0]           mux_sel,
  output logic [ADDR_W-1:0]    inc_addr,
  output logic [JUMP_W-1:0]    jump_addr,
  output logic [CTRL_W-1:0]    ctrl,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = 13 + CTRL_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [IW-1:0]     ir_q;
  logic              first_q;

  // The ROM word is only guaranteed on the first EXEC cycle; a wait-stall replays the captured copy.
  logic [IW-1:0]     instr;
  logic [1:0]        f_nsel;
  logic [1:0]        f_cond;
  logic [JUMP_W-1:0] f_jump;
  logic              f_halt;
  logic              f_wait;
  logic [CTRL_W-1:0] f_ctrl;
  logic              cond_true;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] next_addr;

  assign instr  = first_q ? cs_data : ir_q;
  assign f_nsel = instr[1:0];
  assign f_cond = instr[3:2];
  assign f_jump = instr[4 +: JUMP_W];
  assign f_halt = instr[11];
  assign f_wait = instr[12];
  assign f_ctrl = instr[13 +: CTRL_W];

  always_comb begin
    cond_true = 1'b1;
    case (f_cond)
      2'd0:    cond_true = 1'b1;
      2'd1:    cond_true = z_flag;
      2'd2:    cond_true = ~z_flag;
      default: cond_true = core_done;
    endcase
  end

  always_comb begin
    sel = 2'd0;
    if (state_q == S_EXEC) begin
      case (f_nsel)
        2'd0:    sel = 2'd0;
        2'd1:    sel = 2'd1;
        2'd2:    sel = 2'd2;
        default: sel = cond_true ? 2'd1 : 2'd0;
      endcase
    end
  end

  assign inc_addr = upc_q + ADDR_W'(1);

  always_comb begin
    next_addr = inc_addr;
    case (sel)
      2'd1:    next_addr = {{(ADDR_W-JUMP_W){1'b0}}, f_jump};
      2'd2:    next_addr = map_addr;
      default: next_addr = inc_addr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    cs_rd   = 1'b0;
    ctrl    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          upc_d   = START_ADDR;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cs_rd   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ctrl = f_ctrl;
        if (f_wait && !cond_true) begin
          state_d = S_EXEC;
        end else if (f_halt) begin
          state_d = S_DONE;
        end else begin
          upc_d   = next_addr;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cs_addr   = upc_q;
  assign mux_sel   = sel;
  assign jump_addr = f_jump;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      upc_q   <= START_ADDR;
      ir_q    <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      first_q <= (state_q == S_FETCH);
      if (state_q == S_EXEC) begin
        ir_q <= instr;
      end
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// tb/tb_useq_sequencer.sv - scoreboard bench for useq_sequencer
module tb_useq_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_w = 1'b0;
  logic [15:0] map_addr = 16'h0000;
  logic        z_flag = 1'b0;
  logic        core_done = 1'b0;

  logic [15:0] cs_addr, inc_addr;
  logic        cs_rd, busy, done;
  logic [31:0] cs_data = 32'h0;
  logic [1:0]  mux_sel;
  logic [6:0]  jump_addr;
  logic [18:0] ctrl;

  logic [15:0] cs_addr_w, inc_addr_w;
  logic        cs_rd_w, busy_w, done_w;
  logic [31:0] cs_data_w = 32'h0;
  logic [1:0]  mux_sel_w;
  logic [6:0]  jump_addr_w;
  logic [18:0] ctrl_w;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rom [int];
  logic [15:0] exp_q [$];
  logic [31:0] pend_word;
  logic        chk_pend = 1'b0;
  logic [15:0] mon_e;

  always #5 clk = ~clk;

  useq_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .map_addr(map_addr), .z_flag(z_flag),
    .core_done(core_done), .cs_addr(cs_addr), .cs_rd(cs_rd), .cs_data(cs_data),
    .mux_sel(mux_sel), .inc_addr(inc_addr), .jump_addr(jump_addr), .ctrl(ctrl),
    .busy(busy), .done(done)
  );

  useq_sequencer #(.START_ADDR(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .start(start_w), .map_addr(map_addr), .z_flag(z_flag),
    .core_done(core_done), .cs_addr(cs_addr_w), .cs_rd(cs_rd_w), .cs_data(cs_data_w),
    .mux_sel(mux_sel_w), .inc_addr(inc_addr_w), .jump_addr(jump_addr_w), .ctrl(ctrl_w),
    .busy(busy_w), .done(done_w)
  );

  function automatic logic [31:0] mk(input logic [1:0] ns, input logic [1:0] cd,
                                     input logic [6:0] jp, input logic h, input logic w,
                                     input logic [18:0] c);
    return {c, w, h, jp, cd, ns};
  endfunction

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    if (rom.exists(int'(a))) return rom[int'(a)];
    return mk(2'd0, 2'd0, 7'd0, 1'b1, 1'b0, 19'h0);
  endfunction

  function automatic logic [1:0] exp_sel(input logic [31:0] w);
    logic c;
    case (w[3:2])
      2'd0:    c = 1'b1;
      2'd1:    c = z_flag;
      2'd2:    c = ~z_flag;
      default: c = core_done;
    endcase
    case (w[1:0])
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      2'd2:    return 2'd2;
      default: return c ? 2'd1 : 2'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (cs_rd)   cs_data   <= rom_word(cs_addr);
    if (cs_rd_w) cs_data_w <= rom_word(cs_addr_w);
  end

  // Fetch monitor: every read strobe consumes one expected address; the next cycle is its first EXEC.
  always @(negedge clk) begin
    if (chk_pend) begin
      chk("exec_ctrl", 32'(ctrl), 32'(pend_word[31:13]));
      chk("exec_sel", 32'(mux_sel), 32'(exp_sel(pend_word)));
      chk_pend = 1'b0;
    end
    if (cs_rd && !rst) begin
      chk("fetch_ctrl0", 32'(ctrl), 32'h0);
      chk("fetch_sel0", 32'(mux_sel), 32'h0);
      if (exp_q.size() == 0) begin
        chk("fetch_unexp", 32'(cs_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fetch_addr", 32'(cs_addr), 32'(mon_e));
        pend_word = rom_word(mon_e);
        chk_pend  = 1'b1;
      end
    end
  end

  task automatic run_prog(input string tag, input int exp_lat, input int restart_cyc);
    int cyc;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      start = (cyc == restart_cyc);
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy_done"}, 32'(busy), 32'h1);
    chk({tag, "_ctrl_done"}, 32'(ctrl), 32'h0);
    @(negedge clk);
    chk({tag, "_busy_fall"}, 32'(busy), 32'h0);
    chk({tag, "_done_pulse"}, 32'(done), 32'h0);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_done_main(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 32'h1);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] cnd;
    logic       zv;
    logic       taken;
    int         cyc;

    repeat (3) @(negedge clk);
    chk("rst_cs_rd", 32'(cs_rd), 32'h0);
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_sel", 32'(mux_sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_upc", 32'(cs_addr), 32'h0000);
    chk("rst_upc_w", 32'(cs_addr_w), 32'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    // linear program
    rom.delete();
    for (int i = 0; i < 3; i++) rom[i] = mk(2'd0, 2'd0, 7'd0, 1'b0, 1'b0, 19'(i + 1));
    rom[3] = mk(2'd0, 2'd0, 7'd0, 1'b1, 1'b0, 19'h5A5A);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    run_prog("linear", 8, -1);

    // start while busy is ignored
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    run_prog("restart", 8, 2);

    // jump then map
    rom.delete();
    map_addr = 16'h1234;
    rom[0]       = mk(2'd1, 2'd0, 7'h45, 1'b0, 1'b0, 19'h00A1);
    rom[16'h45]  = mk(2'd2, 2'd0, 7'h00, 1'b0, 1'b0, 19'h00A2);
    rom[16'h1234] = mk(2'd0, 2'd0, 7'h00, 1'b1, 1'b0, 19'h00A3);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0045);
    exp_q.push_back(16'h1234);
    run_prog("jmpmap", 6, -1);

    // conditional branch, both polarities
    for (int c = 0; c < 4; c++) begin
      cnd   = (c < 2) ? 2'd1 : 2'd2;
      zv    = (c % 2 == 0);
      taken = (cnd == 2'd1) ? zv : ~zv;
      z_flag = zv;
      rom.delete();
      rom[0]     = mk(2'd3, cnd, 7'h20, 1'b0, 1'b0, 19'(16'h30 + c));
      rom[16'h20] = mk(2'd0, 2'd0, 7'h00, 1'b1, 1'b0, 19'h0F0F);
      rom[1]     = mk(2'd0, 2'd0, 7'h00, 1'b1, 1'b0, 19'h0E0E);
      exp_q.push_back(16'h0000);
      exp_q.push_back(taken ? 16'h0020 : 16'h0001);
      run_prog("cond", 4, -1);
    end
    z_flag = 1'b0;

    // wait on core_done
    rom.delete();
    rom[0] = mk(2'd0, 2'd3, 7'h00, 1'b0, 1'b1, 19'h7777);
    rom[1] = mk(2'd0, 2'd0, 7'h00, 1'b1, 1'b0, 19'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    core_done = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wait_ctrl", 32'(ctrl), 32'h7777);
      chk("wait_rd", 32'(cs_rd), 32'h0);
      chk("wait_upc", 32'(cs_addr), 32'h0000);
      if (i == 5) core_done = 1'b1;
    end
    @(negedge clk);
    chk("wait_adv", 32'(cs_rd), 32'h1);
    core_done = 1'b0;
    wait_done_main("wait");
    chk("wait_q_empty", 32'(exp_q.size()), 32'h0);

    // uPC wraparound from START_ADDR = FFFF
    rom.delete();
    rom[16'hFFFF] = mk(2'd0, 2'd0, 7'h00, 1'b0, 1'b0, 19'h2222);
    rom[0]        = mk(2'd0, 2'd0, 7'h00, 1'b1, 1'b0, 19'h0003);
    @(negedge clk) start_w = 1'b1;
    @(negedge clk) start_w = 1'b0;
    chk("wrap_f0", 32'(cs_addr_w), 32'hFFFF);
    chk("wrap_inc", 32'(inc_addr_w), 32'h0000);
    @(negedge clk);
    chk("wrap_ctrl", 32'(ctrl_w), 32'h2222);
    @(negedge clk);
    chk("wrap_rd", 32'(cs_rd_w), 32'h1);
    chk("wrap_f1", 32'(cs_addr_w), 32'h0000);
    cyc = 0;
    while (!done_w && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrap_done", 32'(done_w), 32'h1);
    @(negedge clk);

    // reset during EXEC
    rom.delete();
    rom[0]      = mk(2'd1, 2'd0, 7'h10, 1'b0, 1'b0, 19'h0101);
    rom[16'h10] = mk(2'd0, 2'd0, 7'h00, 1'b0, 1'b0, 19'h1111);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0010);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstx_ctrl_pre", 32'(ctrl), 32'h1111);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstx_ctrl", 32'(ctrl), 32'h0);
    chk("rstx_busy", 32'(busy), 32'h0);
    chk("rstx_rd", 32'(cs_rd), 32'h0);
    chk("rstx_upc", 32'(cs_addr), 32'h0000);
    chk("rstx_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    chk("rstx_idle", 32'(busy), 32'h0);
    chk("rstx_q_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
